// File: rtl/wb_select_stage.sv
// wb_select_stage: registered register-file writeback stage for the multicycle MIPS datapath.
// It accepts a request, captures the selected source, formats it as a word, half or byte,
// and presents a one-cycle write strobe (or an error pulse) two cycles after acceptance.
module wb_select_stage #(
    parameter int WIDTH            = 32,
    parameter int NUM_SRC          = 9,
    parameter int SEL_W            = 4,
    parameter int ADDR_W           = 5,
    parameter bit ZERO_REG_PROTECT = 1'b1,
    localparam int OFF_W           = $clog2(WIDTH / 8)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SEL_W-1:0]           req_sel,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [2:0]                 req_fmt,
    input  logic [OFF_W-1:0]           req_offset,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [WIDTH-1:0]           wr_data,
    output logic                       err
);

    typedef enum logic [1:0] {
        IDLE,
        FORMAT,
        WRITE
    } state_t;

    localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W + 1)'(NUM_SRC);

    state_t              state_q, state_d;
    logic                accept;
    logic [WIDTH-1:0]    selData;

    logic [SEL_W-1:0]    capSel_q;
    logic [ADDR_W-1:0]   capAddr_q;
    logic [2:0]          capFmt_q;
    logic [OFF_W-1:0]    capOffset_q;
    logic [WIDTH-1:0]    capData_q;

    logic [WIDTH-1:0]    shifted;
    logic [WIDTH-1:0]    fmtData;
    logic                fmtErr;
    logic                writeAllowed;

    logic                wrEn_q;
    logic                err_q;
    logic [ADDR_W-1:0]   wrAddr_q;
    logic [WIDTH-1:0]    wrData_q;

    // The stage only refuses work while formatting or while held in reset.
    assign req_ready = !reset && (state_q != FORMAT);
    assign accept    = req_valid && req_ready;

    assign wr_en   = wrEn_q;
    assign err     = err_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;

    // Pick the addressed source word; an out-of-range select yields zero and is flagged later.
    always_comb begin
        selData = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_sel == SEL_W'(i)) begin
                selData = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: one FORMAT cycle, one WRITE cycle, back-to-back accepts from WRITE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FORMAT;
            FORMAT:  state_d = WRITE;
            WRITE:   state_d = accept ? FORMAT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request and its source word at the accept edge only.
    always_ff @(posedge clk) begin
        if (reset) begin
            capSel_q    <= '0;
            capAddr_q   <= '0;
            capFmt_q    <= '0;
            capOffset_q <= '0;
            capData_q   <= '0;
        end else if (accept) begin
            capSel_q    <= req_sel;
            capAddr_q   <= req_addr;
            capFmt_q    <= req_fmt;
            capOffset_q <= req_offset;
            capData_q   <= selData;
        end
    end

    // Align the addressed lane to bit 0, then extend it and detect illegal requests.
    always_comb begin
        shifted = capData_q >> {capOffset_q, 3'b000};
        fmtData = '0;
        fmtErr  = 1'b0;
        case (capFmt_q)
            3'd0: begin
                fmtData = shifted;
                fmtErr  = (capOffset_q != '0);
            end
            3'd1: begin
                fmtData = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
                fmtErr  = capOffset_q[0];
            end
            3'd2: begin
                fmtData = {{(WIDTH-16){1'b0}}, shifted[15:0]};
                fmtErr  = capOffset_q[0];
            end
            3'd3:    fmtData = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'd4:    fmtData = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            default: fmtErr  = 1'b1;
        endcase
        if ({1'b0, capSel_q} >= NUM_SRC_L) begin
            fmtErr = 1'b1;
        end
        writeAllowed = !fmtErr && !(ZERO_REG_PROTECT && (capAddr_q == '0));
    end

    // Register the write outputs at the end of FORMAT; strobes fall back to zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrEn_q   <= 1'b0;
            err_q    <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
        end else if (state_q == FORMAT) begin
            wrEn_q   <= writeAllowed;
            err_q    <= fmtErr;
            wrAddr_q <= capAddr_q;
            wrData_q <= fmtErr ? '0 : fmtData;
        end else begin
            wrEn_q   <= 1'b0;
            err_q    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed requests with a scoreboard of expected writes.
module tb_wb_select_stage;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 9;
    localparam int SEL_W   = 4;
    localparam int ADDR_W  = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     req_valid;
    logic                     req_ready, req_ready2;
    logic [SEL_W-1:0]         req_sel;
    logic [ADDR_W-1:0]        req_addr;
    logic [2:0]               req_fmt;
    logic [1:0]               req_offset;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic                     wr_en, wr_en2;
    logic [ADDR_W-1:0]        wr_addr, wr_addr2;
    logic [WIDTH-1:0]         wr_data, wr_data2;
    logic                     err, err2;

    typedef struct packed {
        logic              en;
        logic              er;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } exp_t;

    exp_t sbQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clk = ~clk;

    wb_select_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
                      .ZERO_REG_PROTECT(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_addr(req_addr), .req_fmt(req_fmt), .req_offset(req_offset),
        .src_data(src_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
    );

    wb_select_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
                      .ZERO_REG_PROTECT(1'b0)) dutNoProtect (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
        .req_sel(req_sel), .req_addr(req_addr), .req_fmt(req_fmt), .req_offset(req_offset),
        .src_data(src_data), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .err(err2)
    );

    // One comparison: count it, and report tag/observed/expected when it fails.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic en, input logic er,
                                   input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        exp_t e;
        e.en = en; e.er = er; e.addr = a; e.data = d;
        return e;
    endfunction

    task automatic setSource(input int idx, input logic [WIDTH-1:0] val);
        src_data[idx*WIDTH +: WIDTH] = val;
    endtask

    // Present a request, wait (bounded) until it is accepted, then record its expected write.
    task automatic applyStimulus(input string tag, input logic [SEL_W-1:0] sel,
                                 input logic [ADDR_W-1:0] addr, input logic [2:0] fmt,
                                 input logic [1:0] off, input exp_t e);
        int waitCycles = 0;
        req_sel    = sel;
        req_addr   = addr;
        req_fmt    = fmt;
        req_offset = off;
        req_valid  = 1'b1;
        while (req_ready !== 1'b1 && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (req_ready !== 1'b1) begin
            checkVal({tag, " accept timeout"}, 32'(req_ready), 32'd1);
        end
        @(posedge clk); #1;
        sbQ.push_back(e);
        req_valid = 1'b0;
        checkVal({tag, " ready in FORMAT"}, 32'(req_ready), 32'd0);
        checkVal({tag, " no early strobe"}, 32'(wr_en), 32'd0);
    endtask

    // Advance to the WRITE cycle and compare the outputs with the oldest expectation.
    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk); #1;
        if (sbQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sbQ.pop_front();
            checkVal({tag, " wr_en"},   32'(wr_en),   32'(e.en));
            checkVal({tag, " err"},     32'(err),     32'(e.er));
            checkVal({tag, " wr_addr"}, 32'(wr_addr), 32'(e.addr));
            checkVal({tag, " wr_data"}, wr_data,      e.data);
            checkVal({tag, " ready in WRITE"}, 32'(req_ready), 32'd1);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence.
    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_sel    = '0;
        req_addr   = '0;
        req_fmt    = '0;
        req_offset = '0;
        src_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset ready", 32'(req_ready), 32'd0);
        checkVal("reset wr_en", 32'(wr_en), 32'd0);
        checkVal("reset err", 32'(err), 32'd0);
        checkVal("reset wr_addr", 32'(wr_addr), 32'd0);
        checkVal("reset wr_data", wr_data, 32'd0);
        reset = 1'b0;
        #1;
        checkVal("ready after reset", 32'(req_ready), 32'd1);

        $display("[TB] word write");
        setSource(3, 32'hDEADBEEF);
        applyStimulus("word", 4'd3, 5'd8, 3'd0, 2'd0, mkExp(1'b1, 1'b0, 5'd8, 32'hDEADBEEF));
        checkOutput("word");
        @(posedge clk); #1;
        checkVal("word strobe drops", 32'(wr_en), 32'd0);
        checkVal("word data holds", wr_data, 32'hDEADBEEF);

        $display("[TB] sub-word formatting");
        setSource(0, 32'h80F17F02);
        applyStimulus("byte s off2", 4'd0, 5'd5, 3'd3, 2'd2, mkExp(1'b1, 1'b0, 5'd5, 32'hFFFFFFF1));
        checkOutput("byte s off2");
        applyStimulus("byte u off3", 4'd0, 5'd6, 3'd4, 2'd3, mkExp(1'b1, 1'b0, 5'd6, 32'h00000080));
        checkOutput("byte u off3");
        applyStimulus("half s off2", 4'd0, 5'd7, 3'd1, 2'd2, mkExp(1'b1, 1'b0, 5'd7, 32'hFFFF80F1));
        checkOutput("half s off2");
        applyStimulus("half u off0", 4'd0, 5'd9, 3'd2, 2'd0, mkExp(1'b1, 1'b0, 5'd9, 32'h00007F02));
        checkOutput("half u off0");

        $display("[TB] error cases");
        setSource(8, 32'h0BADF00D);
        applyStimulus("sel oob", 4'd9, 5'd10, 3'd0, 2'd0, mkExp(1'b0, 1'b1, 5'd10, 32'h0));
        checkOutput("sel oob");
        applyStimulus("fmt 101", 4'd0, 5'd11, 3'd5, 2'd0, mkExp(1'b0, 1'b1, 5'd11, 32'h0));
        checkOutput("fmt 101");
        applyStimulus("half off1", 4'd0, 5'd12, 3'd1, 2'd1, mkExp(1'b0, 1'b1, 5'd12, 32'h0));
        checkOutput("half off1");
        applyStimulus("word off2", 4'd0, 5'd13, 3'd0, 2'd2, mkExp(1'b0, 1'b1, 5'd13, 32'h0));
        checkOutput("word off2");
        @(posedge clk); #1;
        checkVal("err drops", 32'(err), 32'd0);

        $display("[TB] zero-register protection");
        setSource(4, 32'h12345678);
        applyStimulus("r0 protect", 4'd4, 5'd0, 3'd0, 2'd0, mkExp(1'b0, 1'b0, 5'd0, 32'h12345678));
        checkOutput("r0 protect");
        checkVal("r0 noprotect wr_en", 32'(wr_en2), 32'd1);
        checkVal("r0 noprotect err", 32'(err2), 32'd0);
        checkVal("r0 noprotect wr_addr", 32'(wr_addr2), 32'd0);
        checkVal("r0 noprotect wr_data", wr_data2, 32'h12345678);
        checkVal("r0 noprotect ready", 32'(req_ready2), 32'd1);

        $display("[TB] back-to-back");
        @(posedge clk); #1;
        setSource(1, 32'h1);
        setSource(2, 32'h2);
        checkVal("b2b ready[0]", 32'(req_ready), 32'd1);
        req_sel = 4'd1; req_addr = 5'd1; req_fmt = 3'd0; req_offset = 2'd0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        sbQ.push_back(mkExp(1'b1, 1'b0, 5'd1, 32'h1));
        checkVal("b2b ready[1]", 32'(req_ready), 32'd0);
        setSource(1, 32'hFFFFFFFF);
        req_sel = 4'd2; req_addr = 5'd2;
        checkOutput("b2b first");
        @(posedge clk); #1;
        sbQ.push_back(mkExp(1'b1, 1'b0, 5'd2, 32'h2));
        req_valid = 1'b0;
        setSource(2, 32'hAAAAAAAA);
        checkVal("b2b ready[3]", 32'(req_ready), 32'd0);
        checkVal("b2b strobe gap", 32'(wr_en), 32'd0);
        checkOutput("b2b second");
        @(posedge clk); #1;
        checkVal("b2b idle strobe", 32'(wr_en), 32'd0);

        $display("[TB] reset mid-operation");
        setSource(5, 32'h55);
        req_sel = 4'd5; req_addr = 5'd3; req_fmt = 3'd0; req_offset = 2'd0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkVal("rst ready forced", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        checkVal("rst wr_en", 32'(wr_en), 32'd0);
        checkVal("rst err", 32'(err), 32'd0);
        checkVal("rst wr_addr", 32'(wr_addr), 32'd0);
        checkVal("rst wr_data", wr_data, 32'd0);
        reset = 1'b0;
        #1;
        checkVal("rst ready after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        checkVal("rst no late write", 32'(wr_en), 32'd0);
        checkVal("rst no late err", 32'(err), 32'd0);

        applyStimulus("post rst", 4'd5, 5'd7, 3'd0, 2'd0, mkExp(1'b1, 1'b0, 5'd7, 32'h55));
        checkOutput("post rst");

        checkVal("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
